smash_out_arbiter: RTL and testbench

- Round-robin, packet-locking arbiter that shares one router output link between NUM_PORTS input smash_fifo instances.
- Selects a non-empty input FIFO and holds the grant for the whole packet (head through tail flit, wormhole style).
- Pops flits from the granted FIFO into the downstream FIFO while the downstream FIFO is not full.
- Sits in the SMASH NoC router, one instance per output direction.

---
 rtl/smash_pkg.sv | 23 ++
 rtl/smash_rr_arbiter.sv | 33 +++
 rtl/smash_out_arbiter.sv | 120 ++++++++++++
 tb/tb_smash_out_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smash_pkg.sv
// Shared SMASH NoC definitions: flit type encoding, arbiter states and the
// flit-type extraction helper used by the output arbiter and route logic.
package smash_pkg;

    localparam logic [1:0] FLIT_TYPE_HEAD   = 2'b10;
    localparam logic [1:0] FLIT_TYPE_BODY   = 2'b00;
    localparam logic [1:0] FLIT_TYPE_TAIL   = 2'b01;
    localparam logic [1:0] FLIT_TYPE_SINGLE = 2'b11;

    // Widest flit the helper accepts; callers zero-extend into this width.
    localparam int FLIT_MAX_W = 64;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    function automatic logic [1:0] flit_type(input logic [FLIT_MAX_W-1:0] flit,
                                             input int data_size);
        return 2'(flit >> (data_size - 2));
    endfunction

endpackage

// File: rtl/smash_rr_arbiter.sv
// Combinational rotating-priority picker: one-hot grant of the first request
// at or after i_ptr, wrapping modulo NUM_PORTS.
module smash_rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]     i_ptr,
    output logic [NUM_PORTS-1:0] o_grant
);

    localparam logic [PTR_W:0] NP_W = (PTR_W + 1)'(NUM_PORTS);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_sum = {1'b0, i_ptr} + (PTR_W + 1)'(i);
            w_idx = PTR_W'((w_sum >= NP_W) ? (w_sum - NP_W) : w_sum);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/smash_out_arbiter.sv
// Packet-locking round-robin arbiter sharing one router output link between
// NUM_PORTS input FIFOs; holds the grant from head flit through tail flit.
module smash_out_arbiter
    import smash_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_SIZE = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_PORTS-1:0]           i_port_en,
    input  logic [NUM_PORTS-1:0]           i_fifo_empty,
    input  logic [NUM_PORTS*DATA_SIZE-1:0] i_fifo_data,
    output logic [NUM_PORTS-1:0]           o_fifo_read,
    input  logic                           i_out_full,
    output logic                           o_out_write,
    output logic [DATA_SIZE-1:0]           o_out_data,
    output logic [NUM_PORTS-1:0]           o_grant,
    output logic                           o_busy,
    output logic                           o_err
);

    localparam int               PTR_W     = $clog2(NUM_PORTS);
    localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

    arb_state_e             r_state, w_state_nxt;
    logic [NUM_PORTS-1:0]   r_grant, w_grant_nxt;
    logic [PTR_W-1:0]       r_ptr, w_ptr_nxt;
    logic                   r_err, w_err_nxt;
    logic                   r_first, w_first_nxt;

    logic [NUM_PORTS-1:0]   w_req, w_pick;
    logic [DATA_SIZE-1:0]   w_data;
    logic [PTR_W-1:0]       w_gidx;
    logic [1:0]             w_type;
    logic                   w_avail, w_xfer, w_is_start, w_is_end;

    assign w_req = ~i_fifo_empty & i_port_en;

    smash_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_rr (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick)
    );

    // Grant is one-hot, so the mux and index encode are simple selects.
    always_comb begin
        w_data = '0;
        w_gidx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (r_grant[k]) begin
                w_data = i_fifo_data[k*DATA_SIZE +: DATA_SIZE];
                w_gidx = PTR_W'(k);
            end
        end
    end

    assign w_avail    = |(r_grant & ~i_fifo_empty);
    assign w_xfer     = (r_state == ST_LOCKED) && w_avail && !i_out_full;
    assign w_type     = flit_type(FLIT_MAX_W'(w_data), DATA_SIZE);
    assign w_is_start = (w_type == FLIT_TYPE_HEAD) || (w_type == FLIT_TYPE_SINGLE);
    assign w_is_end   = (w_type == FLIT_TYPE_TAIL) || (w_type == FLIT_TYPE_SINGLE);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_err_nxt   = r_err;
        w_first_nxt = r_first;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_state_nxt = ST_LOCKED;
                    w_grant_nxt = w_pick;
                    w_first_nxt = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (w_xfer) begin
                    w_first_nxt = 1'b0;
                    // Packet must open with a start flit and never restart mid-packet.
                    if (r_first != w_is_start) w_err_nxt = 1'b1;
                    if (w_is_end) begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = '0;
                        w_ptr_nxt   = (w_gidx == LAST_PORT) ? '0 : w_gidx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_err   <= 1'b0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_err   <= w_err_nxt;
            r_first <= w_first_nxt;
        end
    end

    assign o_out_write = w_xfer;
    assign o_fifo_read = r_grant & {NUM_PORTS{w_xfer}};
    assign o_out_data  = (r_state == ST_LOCKED) ? w_data : '0;
    assign o_grant     = r_grant;
    assign o_busy      = (r_state == ST_LOCKED);
    assign o_err       = r_err;

endmodule

// File: tb/tb_smash_out_arbiter.sv
// Scoreboard bench for smash_out_arbiter: bench-owned input FIFOs, a
// packet-level round-robin reference model, and an independent output monitor.
module tb_smash_out_arbiter;

    localparam int NP = 4;
    localparam int DS = 32;

    logic            clk = 1'b0;
    logic            i_rst;
    logic [NP-1:0]   i_port_en;
    logic [NP-1:0]   i_fifo_empty;
    logic [NP*DS-1:0] i_fifo_data;
    logic [NP-1:0]   o_fifo_read;
    logic            i_out_full;
    logic            o_out_write;
    logic [DS-1:0]   o_out_data;
    logic [NP-1:0]   o_grant;
    logic            o_busy;
    logic            o_err;

    smash_out_arbiter #(.NUM_PORTS(NP), .DATA_SIZE(DS)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_port_en    (i_port_en),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_data  (i_fifo_data),
        .o_fifo_read  (o_fifo_read),
        .i_out_full   (i_out_full),
        .o_out_write  (o_out_write),
        .o_out_data   (o_out_data),
        .o_grant      (o_grant),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    logic [DS-1:0] fq[NP][$];   // contents of the input FIFOs as the DUT sees them
    logic [DS-1:0] mq[NP][$];   // reference model's view of queued packets
    logic [DS-1:0] exp_q[$];    // expected output flit stream
    int            m_ptr = 0;
    logic          stall = 1'b0;
    logic [NP-1:0] rd_cap = '0;
    int            n_vec = 0;
    int            n_bad = 0;

    task automatic chk(input string name, input logic [DS-1:0] act, input logic [DS-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int k, input logic [DS-1:0] f, input bit to_model);
        fq[k].push_back(f);
        if (to_model) mq[k].push_back(f);
    endtask

    // Whole packets leave in round-robin order over enabled ports with data.
    task automatic model_run(input logic [NP-1:0] en);
        int g;
        bit done;
        logic [DS-1:0] f;
        forever begin
            g = -1;
            for (int i = 0; i < NP; i++) begin
                int k;
                k = (m_ptr + i) % NP;
                if (g < 0 && en[k] && mq[k].size() > 0) g = k;
            end
            if (g < 0) break;
            done = 1'b0;
            while (!done && mq[g].size() > 0) begin
                f = mq[g].pop_front();
                exp_q.push_back(f);
                done = (f[DS-1:DS-2] inside {2'b01, 2'b11});
            end
            m_ptr = (g + 1) % NP;
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic wait_drain(input bit rnd);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (rnd) begin
                i_out_full = ($urandom_range(0, 9) < 3);
                stall      = o_busy && ($urandom_range(0, 9) < 3);
            end
            #4;
            ok = (exp_q.size() == 0) && !o_busy;
        end
        i_out_full = 1'b0;
        stall      = 1'b0;
        chk("drain", 32'(ok), 32'd1);
    endtask

    // Input FIFO model: pop on captured strobes, then present head/empty.
    initial begin
        i_fifo_empty = '1;
        i_fifo_data  = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NP; k++)
                if (rd_cap[k] && fq[k].size() > 0) void'(fq[k].pop_front());
            #1;
            for (int k = 0; k < NP; k++) begin
                i_fifo_empty[k] = (fq[k].size() == 0) || stall;
                i_fifo_data[k*DS +: DS] = (fq[k].size() > 0) ? fq[k][0] : '0;
            end
            #1;
            rd_cap = o_fifo_read;
        end
    end

    // Monitor: compares every written flit against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            chk("rd_onehot", 32'($onehot0(o_fifo_read)), 32'd1);
            if (o_out_write) begin
                chk("wr_while_full", 32'(i_out_full), 32'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious_write: got %h, expected no write at %0t", o_out_data, $time);
                end else begin
                    chk("out_data", o_out_data, exp_q.pop_front());
                end
            end
            if (!o_busy) chk("idle_data", o_out_data, 32'd0);
        end
    end

    initial begin
        logic [NP-1:0] en;
        int npk, len;
        i_rst      = 1'b0;
        i_port_en  = '1;
        i_out_full = 1'b0;
        repeat (2) tick();
        settle();
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_busy",  32'(o_busy),  32'd0);
        chk("rst_err",   32'(o_err),   32'd0);
        tick(); i_rst = 1'b1;

        // Single packet on port 1
        tick();
        push(1, 32'h8000_0001, 1); push(1, 32'h0000_0002, 1); push(1, 32'h4000_0003, 1);
        model_run('1);
        tick(); settle();
        chk("t1_grant", 32'(o_grant), 32'b0010);
        chk("t1_wr0", 32'(o_out_write), 32'd1);
        tick(); settle(); chk("t1_wr1", 32'(o_out_write), 32'd1);
        tick(); settle(); chk("t1_wr2", 32'(o_out_write), 32'd1);
        tick(); settle();
        chk("t1_busy", 32'(o_busy), 32'd0);
        chk("t1_err",  32'(o_err),  32'd0);
        wait_drain(0);

        // Round robin from a fresh pointer
        tick(); i_rst = 1'b0; m_ptr = 0;
        tick(); i_rst = 1'b1;
        tick();
        push(0, 32'hC000_0000, 1); push(2, 32'hC000_0002, 1); push(3, 32'hC000_0003, 1);
        model_run('1);
        wait_drain(0);
        tick();
        push(0, 32'hC000_0010, 1); push(2, 32'hC000_0012, 1);
        model_run('1);
        wait_drain(0);

        // Downstream backpressure mid-packet
        tick();
        push(3, 32'h8000_0030, 1); push(3, 32'h0000_0031, 1);
        push(3, 32'h0000_0032, 1); push(3, 32'h4000_0033, 1);
        model_run('1);
        tick(); settle(); chk("t3_wr_head", 32'(o_out_write), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(); i_out_full = 1'b1; settle();
            chk("t3_bp_wr",    32'(o_out_write), 32'd0);
            chk("t3_bp_rd",    32'(o_fifo_read), 32'd0);
            chk("t3_bp_grant", 32'(o_grant),     32'b1000);
        end
        tick(); i_out_full = 1'b0; settle();
        chk("t3_resume", 32'(o_out_write), 32'd1);
        wait_drain(0);

        // Lock held across an upstream gap while port 1 waits
        tick();
        push(0, 32'h8000_0040, 1);
        mq[0].push_back(32'h0000_0041); mq[0].push_back(32'h4000_0042);
        push(1, 32'hC000_0043, 1);
        model_run('1);
        tick(); settle();
        chk("t4_grant0", 32'(o_grant), 32'b0001);
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            chk("t4_lock", 32'(o_grant), 32'b0001);
            chk("t4_gap_wr", 32'(o_out_write), 32'd0);
        end
        tick(); push(0, 32'h0000_0041, 0); push(0, 32'h4000_0042, 0); settle();
        chk("t4_body_wr", 32'(o_out_write), 32'd1);
        tick(); settle(); chk("t4_tail_grant", 32'(o_grant), 32'b0001);
        tick(); settle(); chk("t4_bubble", 32'(o_busy), 32'd0);
        tick(); settle(); chk("t4_next_grant", 32'(o_grant), 32'b0010);
        wait_drain(0);

        // Packet opening with a BODY flit
        tick();
        push(2, 32'h0000_00AA, 1); push(2, 32'h4000_00AB, 1);
        model_run('1);
        tick(); settle();
        chk("t5_grant", 32'(o_grant), 32'b0100);
        chk("t5_err_pre", 32'(o_err), 32'd0);
        tick(); settle(); chk("t5_err_set", 32'(o_err), 32'd1);
        wait_drain(0);
        repeat (3) tick();
        settle(); chk("t5_err_sticky", 32'(o_err), 32'd1);

        // Reset mid-packet
        tick();
        push(1, 32'h8000_0060, 0); push(1, 32'h0000_0061, 0);
        exp_q.push_back(32'h8000_0060); exp_q.push_back(32'h0000_0061);
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin tick(); #4; end
        tick(); settle();
        chk("t6_locked", 32'(o_grant), 32'b0010);
        tick(); i_rst = 1'b0; m_ptr = 0;
        tick(); i_rst = 1'b1; settle();
        chk("t6_grant", 32'(o_grant),     32'd0);
        chk("t6_busy",  32'(o_busy),      32'd0);
        chk("t6_rd",    32'(o_fifo_read), 32'd0);
        chk("t6_err",   32'(o_err),       32'd0);
        tick();
        push(3, 32'hC000_0063, 1); push(0, 32'hC000_0060, 1);
        model_run('1);
        tick(); settle(); chk("t6_port0_first", 32'(o_grant), 32'b0001);
        wait_drain(0);

        // Randomized rounds with enables, backpressure and upstream gaps
        for (int r = 0; r < 40; r++) begin
            tick();
            en = NP'($urandom_range(1, (1 << NP) - 1));
            i_port_en = en;
            for (int k = 0; k < NP; k++) begin
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 4);
                    if (len == 1) push(k, {2'b11, 30'($urandom)}, 1);
                    else begin
                        push(k, {2'b10, 30'($urandom)}, 1);
                        for (int b = 0; b < len - 2; b++) push(k, {2'b00, 30'($urandom)}, 1);
                        push(k, {2'b01, 30'($urandom)}, 1);
                    end
                end
            end
            model_run(en);
            wait_drain(1);
        end
        tick();
        i_port_en = '1;
        model_run('1);
        wait_drain(1);
        chk("rand_err", 32'(o_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
